// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Direct-mapped BTB with a 2-bit saturating counter per entry.
//             Combinational fetch-stage lookup, execute-stage training,
//             misprediction detection, corrected fetch PC and saturating
//             performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Fetch-stage lookup
    input  logic [WIDTH-1:0]     pc_f,
    output logic                 predict_taken_f,
    output logic [WIDTH-1:0]     predict_target_f,
    // Execute-stage resolution
    input  logic                 branch_e,
    input  logic [WIDTH-1:0]     pc_e,
    input  logic                 taken_e,
    input  logic [WIDTH-1:0]     target_e,
    input  logic                 pred_taken_e,
    input  logic [WIDTH-1:0]     pred_target_e,
    output logic                 branch,
    output logic                 branch_resolved,
    output logic [WIDTH-1:0]     redirect_pc_e,
    // Performance counters
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WIDTH - INDEX_BITS - 2;

    // Table storage, one slot per index
    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [WIDTH-1:0]     target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];

    // ------------------------------------------------------------------
    // Fetch-side lookup (reads only registered state, so a same-cycle
    // update is not visible until the following cycle)
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] idx_f;
    logic [TAG_W-1:0]      tag_f;
    logic                  hit_f;

    assign idx_f = pc_f[INDEX_BITS+1:2];
    assign tag_f = pc_f[WIDTH-1:INDEX_BITS+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign predict_taken_f  = hit_f && ctr_q[idx_f][1];
    assign predict_target_f = predict_taken_f ? target_q[idx_f] : (pc_f + WIDTH'(4));

    // ------------------------------------------------------------------
    // Execute-side resolution
    // ------------------------------------------------------------------
    logic mispredict;

    assign mispredict      = branch_e && ((taken_e != pred_taken_e) ||
                                          (taken_e && (target_e != pred_target_e)));
    assign branch          = branch_e;
    assign branch_resolved = branch_e && !mispredict;
    assign redirect_pc_e   = taken_e ? target_e : (pc_e + WIDTH'(4));

    // ------------------------------------------------------------------
    // Training: compute the new contents of the entry addressed by pc_e
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_W-1:0]      tag_e;
    logic                  hit_e;
    logic                  wr_en;
    logic                  valid_d;
    logic [TAG_W-1:0]      tag_d;
    logic [WIDTH-1:0]      target_d;
    logic [1:0]            ctr_d;

    assign idx_e = pc_e[INDEX_BITS+1:2];
    assign tag_e = pc_e[WIDTH-1:INDEX_BITS+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    // Next-state of the execute-indexed entry; a not-taken miss leaves it alone
    always_comb begin
        wr_en    = 1'b0;
        valid_d  = valid_q[idx_e];
        tag_d    = tag_q[idx_e];
        target_d = target_q[idx_e];
        ctr_d    = ctr_q[idx_e];
        if (branch_e) begin
            if (hit_e) begin
                wr_en = 1'b1;
                if (taken_e) begin
                    ctr_d    = (ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'd1;
                    target_d = target_e;
                end else begin
                    ctr_d    = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1;
                end
            end else if (taken_e) begin
                // Allocate over whatever lived here, starting weakly taken
                wr_en    = 1'b1;
                valid_d  = 1'b1;
                tag_d    = tag_e;
                target_d = target_e;
                ctr_d    = 2'b10;
            end
        end
    end

    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
            // Per-entry storage; reset leaves every entry invalid and weakly not-taken
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q[g]  <= 1'b0;
                    tag_q[g]    <= '0;
                    target_q[g] <= '0;
                    ctr_q[g]    <= 2'b01;
                end else if (wr_en && (idx_e == INDEX_BITS'(g))) begin
                    valid_q[g]  <= valid_d;
                    tag_q[g]    <= tag_d;
                    target_q[g] <= target_d;
                    ctr_q[g]    <= ctr_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Performance counters, saturating at all-ones
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q,   miss_cnt_d;

    // Increment when the event fires unless already pinned at the maximum
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (branch_e && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (mispredict && !(&miss_cnt_q)) begin
            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor
//  Purpose  : Self-checking bench for branch_predictor with a behavioural
//             table model; directed scenarios followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int W    = 32;
    localparam int IB   = 4;
    localparam int CW   = 4;
    localparam int NENT = 16;
    localparam int CMAX = 15;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  pc_f;
    logic          predict_taken_f;
    logic [W-1:0]  predict_target_f;
    logic          branch_e;
    logic [W-1:0]  pc_e;
    logic          taken_e;
    logic [W-1:0]  target_e;
    logic          pred_taken_e;
    logic [W-1:0]  pred_target_e;
    logic          branch;
    logic          branch_resolved;
    logic [W-1:0]  redirect_pc_e;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.WIDTH(W), .INDEX_BITS(IB), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_f             (pc_f),
        .predict_taken_f  (predict_taken_f),
        .predict_target_f (predict_target_f),
        .branch_e         (branch_e),
        .pc_e             (pc_e),
        .taken_e          (taken_e),
        .target_e         (target_e),
        .pred_taken_e     (pred_taken_e),
        .pred_target_e    (pred_target_e),
        .branch           (branch),
        .branch_resolved  (branch_resolved),
        .redirect_pc_e    (redirect_pc_e),
        .branch_cnt       (branch_cnt),
        .miss_cnt         (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a table of entries with an integer confidence 0..3
    bit          m_valid  [NENT];
    int unsigned m_tag    [NENT];
    logic [31:0] m_target [NENT];
    int          m_ctr    [NENT];
    int          m_bcnt;
    int          m_mcnt;

    function automatic void m_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i;
        i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == (pc >> (IB + 2)));
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
        int i;
        i   = m_idx(pc);
        tk  = m_hit(pc) && (m_ctr[i] >= 2);
        tgt = tk ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic void m_train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                    input bit mis);
        int i;
        i      = m_idx(pc);
        m_bcnt = (m_bcnt + 1 > CMAX) ? CMAX : m_bcnt + 1;
        if (mis) m_mcnt = (m_mcnt + 1 > CMAX) ? CMAX : m_mcnt + 1;
        if (m_hit(pc)) begin
            if (tk) begin
                m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = tgt;
            end else begin
                m_ctr[i]    = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = pc >> (IB + 2);
            m_target[i] = tgt;
            m_ctr[i]    = 2;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check combinational outputs,
    // then advance the model at the rising edge and check the counters.
    task automatic step(input logic [31:0] pcf, input logic be, input logic [31:0] pce,
                        input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
        logic        etk;
        logic [31:0] etgt;
        bit          emis;
        @(negedge clk);
        pc_f = pcf; branch_e = be; pc_e = pce; taken_e = tk; target_e = tgt;
        pred_taken_e = ptk; pred_target_e = ptgt;
        #1;
        m_lookup(pcf, etk, etgt);
        emis = be && ((tk != ptk) || (tk && (tgt != ptgt)));
        check("predict_taken_f", 32'(predict_taken_f), 32'(etk));
        check("predict_target_f", predict_target_f, etgt);
        check("branch", 32'(branch), 32'(be));
        check("branch_resolved", 32'(branch_resolved), 32'(be && !emis));
        check("redirect_pc_e", redirect_pc_e, tk ? tgt : pce + 32'd4);
        @(posedge clk);
        if (be) m_train(pce, tk, tgt, emis);
        #1;
        check("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
        check("miss_cnt", 32'(miss_cnt), 32'(m_mcnt));
    endtask

    // Resolve a branch whose carried prediction is what the table says now
    task automatic resolve(input logic [31:0] pcf, input logic [31:0] pce,
                           input logic tk, input logic [31:0] tgt);
        logic        ptk;
        logic [31:0] ptgt;
        m_lookup(pce, ptk, ptgt);
        step(pcf, 1'b1, pce, tk, tgt, ptk, ptgt);
    endtask

    task automatic idle(input logic [31:0] pcf);
        step(pcf, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    logic [31:0] pool [8];

    initial begin
        pool[0] = 32'h40;   pool[1] = 32'h440;  pool[2] = 32'h80;   pool[3] = 32'h200;
        pool[4] = 32'h1000; pool[5] = 32'h1040; pool[6] = 32'h3C;   pool[7] = 32'h7C;

        // Power-on reset
        rst_n = 1'b0; pc_f = 32'h100; branch_e = 1'b0; pc_e = '0; taken_e = 1'b0;
        target_e = '0; pred_taken_e = 1'b0; pred_target_e = '0;
        m_reset();
        #3;
        check("rst_predict_taken", 32'(predict_taken_f), 32'h0);
        check("rst_predict_target", predict_target_f, 32'h104);
        check("rst_branch_cnt", 32'(branch_cnt), 32'h0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cold taken branch at 0x40, fetch of 0x40 in the same cycle sees a miss
        step(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        idle(32'h40);

        // Train towards strong-taken, then back down and into saturation at 00
        repeat (3) resolve(32'h40, 32'h40, 1'b1, 32'h80);
        repeat (4) resolve(32'h40, 32'h40, 1'b0, 32'h80);
        resolve(32'h40, 32'h40, 1'b1, 32'h80);
        idle(32'h40);

        // Not-taken miss does not allocate; aliasing entry evicts 0x40
        resolve(32'h200, 32'h200, 1'b0, 32'h0);
        idle(32'h200);
        resolve(32'h40, 32'h440, 1'b1, 32'h900);
        idle(32'h40);
        idle(32'h440);

        // Target mismatch retrains the target
        resolve(32'h40, 32'h40, 1'b1, 32'h80);
        step(32'h40, 1'b1, 32'h40, 1'b1, 32'h90, 1'b1, 32'h80);
        idle(32'h40);

        // Random traffic; counters saturate early with a 4-bit width
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pcf, pce, tgt, ptgt;
            logic        be, tk, ptk;
            pcf = pool[$urandom_range(7)] | 32'($urandom_range(3));
            pce = pool[$urandom_range(7)];
            be  = ($urandom_range(9) < 7);
            tk  = $urandom_range(1) == 1;
            tgt = $urandom & 32'hFFFF_FFFC;
            m_lookup(pce, ptk, ptgt);
            if ($urandom_range(3) == 0) begin
                ptk  = $urandom_range(1) == 1;
                ptgt = $urandom & 32'hFFFF_FFFC;
            end
            step(pcf, be, pce, tk, tgt, ptk, ptgt);
        end

        // Asynchronous reset landing mid-update: the update is lost
        resolve(32'h100, 32'h100, 1'b1, 32'h500);
        resolve(32'h100, 32'h100, 1'b1, 32'h500);
        idle(32'h100);
        @(negedge clk);
        pc_f = 32'h100; branch_e = 1'b1; pc_e = 32'h140; taken_e = 1'b1;
        target_e = 32'h300; pred_taken_e = 1'b0; pred_target_e = 32'h144;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async_predict_taken", 32'(predict_taken_f), 32'h0);
        check("async_predict_target", predict_target_f, 32'h104);
        check("async_branch_cnt", 32'(branch_cnt), 32'h0);
        check("async_miss_cnt", 32'(miss_cnt), 32'h0);
        check("async_branch_passthru", 32'(branch), 32'h1);
        @(posedge clk);
        #1;
        check("held_branch_cnt", 32'(branch_cnt), 32'h0);
        @(negedge clk);
        branch_e = 1'b0;
        rst_n = 1'b1;
        idle(32'h140);
        idle(32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
